// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction-fetch controller for the MIPS core.
// Owns the PC register, drives the imem request/ack handshake, buffers one
// fetched instruction for decode and applies redirects resolved by decode.
// Optional exception entry is built when PCSEQ_EXC_EN is defined.
//
// state | meaning
// ------+-------------------------------------------------------------
// REQ   | fetch request at curPC outstanding (imem_req=1)
// VALID | instr/instr_pc hold a valid instruction for decode
// DROP  | killed request still in flight at the old address; data discarded
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
`ifdef PCSEQ_EXC_EN
    ,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
`endif
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [1:0]  PCSrc,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    input  logic [31:0] immediate,
    input  logic [25:0] addr,
    input  logic [31:0] rs,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
`ifdef PCSEQ_EXC_EN
    input  logic        exc,
    output logic [31:0] epc,
`endif
    output logic [31:0] curPC
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_VALID = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic [31:0] drop_addr_q, drop_addr_d;
`ifdef PCSEQ_EXC_EN
    logic [31:0] epc_q, epc_d;
`endif

    logic [31:0] seq_pc;
    logic [31:0] redir_target;
    logic        take;
    logic [31:0] take_target;

    // Redirect target for each control-transfer kind.
    always_comb begin
        seq_pc       = redir_pc + 32'd4;
        redir_target = seq_pc;
        case (PCSrc)
            2'b01:   redir_target = seq_pc + (immediate << 2);
            2'b10:   redir_target = rs & 32'hFFFF_FFFC;
            2'b11:   redir_target = {seq_pc[31:28], addr, 2'b00};
            default: redir_target = seq_pc;
        endcase
    end

    // Exceptions reuse the redirect kill path, with priority over redirects.
    always_comb begin
`ifdef PCSEQ_EXC_EN
        take        = exc | redir_valid;
        take_target = exc ? EXC_VECTOR : redir_target;
`else
        take        = redir_valid;
        take_target = redir_target;
`endif
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        drop_addr_d = drop_addr_q;
`ifdef PCSEQ_EXC_EN
        epc_d       = epc_q;
        if (exc) begin
            epc_d = (state_q == S_VALID) ? instr_pc_q : pc_q;
        end
`endif
        case (state_q)
            S_REQ: begin
                if (take) begin
                    pc_d        = take_target;
                    drop_addr_d = pc_q;
                    state_d     = imem_ack ? S_REQ : S_DROP;
                end else if (imem_ack) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    pc_d       = pc_q + 32'd4;
                    state_d    = S_VALID;
                end
            end
            S_VALID: begin
                if (take) begin
                    pc_d    = take_target;
                    state_d = S_REQ;
                end else if (instr_ready && !stall) begin
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (take) begin
                    pc_d = take_target;
                end
                if (imem_ack) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // State and datapath registers; reset abandons any outstanding request.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            instr_q     <= 32'd0;
            instr_pc_q  <= 32'd0;
            drop_addr_q <= 32'd0;
`ifdef PCSEQ_EXC_EN
            epc_q       <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            drop_addr_q <= drop_addr_d;
`ifdef PCSEQ_EXC_EN
            epc_q       <= epc_d;
`endif
        end
    end

    // Request is gated by RST so nothing is issued while reset is held.
    always_comb begin
        imem_req    = !RST && (state_q != S_VALID);
        imem_addr   = (state_q == S_DROP) ? drop_addr_q : pc_q;
        instr_valid = (state_q == S_VALID);
        instr       = instr_q;
        instr_pc    = instr_pc_q;
        curPC       = pc_q;
`ifdef PCSEQ_EXC_EN
        epc         = epc_q;
`endif
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer. Exception checks are built when
// PCSEQ_EXC_EN is defined.
module tb_pc_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  PCSrc;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic [31:0] immediate;
    logic [25:0] addr;
    logic [31:0] rs;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic [31:0] curPC;
`ifdef PCSEQ_EXC_EN
    logic        exc;
    logic [31:0] epc;
`endif

    int n_cmp = 0;
    int n_err = 0;

    pc_sequencer dut (
        .CLK         (CLK),
        .RST         (RST),
        .PCSrc       (PCSrc),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .immediate   (immediate),
        .addr        (addr),
        .rs          (rs),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
`ifdef PCSEQ_EXC_EN
        .exc         (exc),
        .epc         (epc),
`endif
        .curPC       (curPC)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic redir(input logic [1:0] kind, input logic [31:0] rpc);
        redir_valid = 1'b1;
        PCSrc       = kind;
        redir_pc    = rpc;
    endtask

    initial begin
        RST = 1'b1; PCSrc = 2'b00; redir_valid = 1'b0; redir_pc = '0;
        immediate = '0; addr = '0; rs = '0; stall = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b1;
`ifdef PCSEQ_EXC_EN
        exc = 1'b0;
`endif
        imem_ack = 1'b1;              // ack during reset must be ignored
        tick(); tick();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_pc", curPC, 32'h0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        RST = 1'b0; imem_ack = 1'b0;
        #1;
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);
        chk("post_rst_addr", imem_addr, 32'h0);

        // Zero-wait fetch of 0x0, 0x4, 0x8, one every second cycle.
        for (int i = 0; i < 3; i++) begin
            chk("zw_addr", imem_addr, 32'(i * 4));
            chk("zw_req", {31'd0, imem_req}, 32'd1);
            imem_ack = 1'b1; imem_rdata = mem(32'(i * 4));
            tick();
            imem_ack = 1'b0;
            chk("zw_valid", {31'd0, instr_valid}, 32'd1);
            chk("zw_instr_pc", instr_pc, 32'(i * 4));
            chk("zw_instr", instr, mem(32'(i * 4)));
            chk("zw_req_off", {31'd0, imem_req}, 32'd0);
            if (i < 2) tick();
        end
        chk("zw_curpc", curPC, 32'hC);

        // Branch in VALID: 0x100 + 4 + (-2 << 2) = 0xFC.
        redir(2'b01, 32'h100); immediate = 32'hFFFF_FFFE;
        tick();
        redir_valid = 1'b0;
        chk("br_addr", imem_addr, 32'hFC);
        chk("br_valid", {31'd0, instr_valid}, 32'd0);

        // Jump in REQ with same-cycle ack: data discarded, stay in REQ.
        redir(2'b11, 32'h4000_0010); addr = 26'h0000040;
        imem_ack = 1'b1; imem_rdata = mem(32'hFC);
        tick();
        chk("jmp_addr", imem_addr, 32'h4000_0100);
        chk("jmp_valid", {31'd0, instr_valid}, 32'd0);
        chk("jmp_instr_pc", instr_pc, 32'h8);

        // jr with misaligned register: low bits forced to zero.
        redir(2'b10, 32'h0); rs = 32'h0000_1003;
        tick();
        chk("jr_addr", imem_addr, 32'h0000_1000);

        // Sequential redirect: redir_pc + 4.
        redir(2'b00, 32'h200);
        tick();
        redir_valid = 1'b0; imem_ack = 1'b0;
        chk("seq_addr", imem_addr, 32'h204);

        // Slow memory, redirect in the second wait cycle, ack in the third.
        tick();
        chk("slow_w1_addr", imem_addr, 32'h204);
        redir(2'b01, 32'h300); immediate = 32'h1;
        tick();
        redir_valid = 1'b0;
        chk("drop_addr", imem_addr, 32'h204);
        chk("drop_req", {31'd0, imem_req}, 32'd1);
        chk("drop_curpc", curPC, 32'h308);
        imem_ack = 1'b1; imem_rdata = mem(32'h204);
        tick();
        chk("drop_valid", {31'd0, instr_valid}, 32'd0);
        chk("drop_new_addr", imem_addr, 32'h308);
        chk("drop_instr_pc", instr_pc, 32'h8);
        imem_rdata = mem(32'h308);
        tick();
        imem_ack = 1'b0;
        chk("tgt_instr_pc", instr_pc, 32'h308);
        chk("tgt_instr", instr, mem(32'h308));

        // Stall for 5 cycles in VALID.
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
            chk("stall_instr_pc", instr_pc, 32'h308);
        end
        stall = 1'b0;
        tick();
        chk("unstall_req", {31'd0, imem_req}, 32'd1);
        chk("unstall_addr", imem_addr, 32'h30C);

        // Decode not ready: VALID holds.
        instr_ready = 1'b0;
        imem_ack = 1'b1; imem_rdata = mem(32'h30C);
        tick();
        imem_ack = 1'b0;
        tick();
        chk("hold_valid", {31'd0, instr_valid}, 32'd1);
        chk("hold_instr", instr, mem(32'h30C));
        instr_ready = 1'b1;

`ifdef PCSEQ_EXC_EN
        // Exception in VALID captures instr_pc.
        exc = 1'b1;
        tick();
        exc = 1'b0;
        chk("exc_epc", epc, 32'h30C);
        chk("exc_addr", imem_addr, 32'h180);
        // Exception beats a simultaneous redirect; epc takes curPC in REQ.
        exc = 1'b1; redir(2'b00, 32'h500); imem_ack = 1'b1;
        tick();
        exc = 1'b0; redir_valid = 1'b0; imem_ack = 1'b0;
        chk("exc_pri_addr", imem_addr, 32'h180);
        chk("exc_pri_epc", epc, 32'h180);
`endif

        // Reset mid-request with an ack in flight.
        tick();
        RST = 1'b1; imem_ack = 1'b1;
        tick();
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        chk("mid_rst_pc", curPC, 32'h0);
        chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("mid_rst_instr", instr, 32'd0);
        RST = 1'b0; imem_ack = 1'b0;
        #1;
        chk("mid_rst_addr", imem_addr, 32'h0);
        chk("mid_rst_req1", {31'd0, imem_req}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Instruction-fetch controller for the MIPS core. It owns the program-counter register and drives the instruction-memory request/acknowledge handshake. It buffers one fetched instruction for decode. It applies control-transfer redirects (branch, jr, jump) resolved by decode, and holds the buffered instruction while the hazard unit stalls. The next-address adder sits inside this block; decode consumes `instr`/`instr_pc`.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `EXC_VECTOR`, 32'h0000_0180, exception entry address (used only with `PCSEQ_EXC_EN`)

- `CLK`  in  1  clock, all state on rising edge
- `RST`  in  1  reset; one clock, reset is synchronous and active-high
- `PCSrc`  in  2  redirect kind: 00 seq, 01 branch, 10 jr, 11 jump; sampled only with `redir_valid`
- `redir_valid`  in  1  decode resolved a taken control transfer this cycle
- `redir_pc`  in  32  address of the control-transfer instruction
- `immediate`  in  32  sign-extended branch offset in words
- `addr`  in  26  jump target field
- `rs`  in  32  jr target register value
- `stall`  in  1  hazard unit holds decode
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  fetch address; stable while `imem_req`=1 until `imem_ack`
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle
- `imem_rdata`  in  32  fetched word
- `instr_valid`  out  1  `instr` holds a valid instruction
- `instr`  out  32  buffered instruction
- `instr_pc`  out  32  address of `instr`
- `instr_ready`  in  1  decode accepts `instr`
- `curPC`  out  32  PC register, the next fetch address
- `exc`  in  1  exception request (only with `PCSEQ_EXC_EN`)
- `epc`  out  32  exception return address (only with `PCSEQ_EXC_EN`)

## Operation
- **States:**
  - REQ: `imem_req`=1, `imem_addr`=`curPC`.
  - VALID: `instr_valid`=1.
  - DROP: request in flight but killed; `imem_req`=1 with the old address.
- **REQ:**
  - If `imem_ack`: `instr`<=`imem_rdata`, `instr_pc`<=`curPC`, `curPC`<=`curPC`+4, go to VALID.
- **VALID:**
  - If `instr_ready` && !`stall`: go to REQ; `instr_valid` drops next cycle.
  - Otherwise hold `instr`/`instr_pc` unchanged.
- **Redirect target**, all arithmetic mod 2^32:
  - 01 branch: `redir_pc`+4+(`immediate`<<2).
  - 10 jr: {`rs`[31:2],2'b00}; misaligned low bits are forced to zero.
  - 11 jump: {(`redir_pc`+4)[31:28],`addr`,2'b00}.
  - 00 with `redir_valid`: `redir_pc`+4.
- **Redirect in REQ:**
  - With `imem_ack` the same cycle: data discarded, `curPC`<=target, stay in REQ.
  - Without `imem_ack`: `curPC`<=target, go to DROP. DROP keeps `imem_addr`=old address until `imem_ack`, discards the data, then goes to REQ.
- **Redirect in VALID:** `instr_valid`<=0, `curPC`<=target, go to REQ. This applies regardless of `stall`.
- **Redirect in DROP:** `curPC`<=target; the state stays DROP, or goes to REQ if `imem_ack`.
- **Priority:** `RST` > `exc` > `redir_valid` > normal sequencing.
- `stall` never blocks an in-flight request; it only holds VALID.

## Timing
- **Reset values:**
  - State REQ, `curPC`=`RESET_PC`.
  - `imem_req`=0 during reset; it becomes 1 in the first cycle after `RST` falls.
  - `instr_valid`=0, `instr`=0, `instr_pc`=0, `epc`=0.
- `imem_addr` is combinational from the state: `curPC` in REQ, the latched old address in DROP.
- **Zero-wait memory:** `imem_ack` in the REQ cycle gives `instr_valid`=1 on the next cycle. Sustained throughput is one instruction per 2 cycles.
- **N-cycle memory:** latency from REQ entry to `instr_valid` is N+1 cycles.
- A redirect in cycle t makes `imem_addr`=target at t+1 when the state was VALID, or when it was REQ with an ack at t.
- Reset mid-operation abandons any outstanding request. `imem_ack` arriving while `RST`=1 is ignored. The memory is reset by the same `RST`.

## Configuration
- `PCSEQ_EXC_EN` defined:
  - The `exc` and `epc` ports exist.
  - An `exc` pulse sets `epc`<=`instr_pc` if `instr_valid`, else `curPC`.
  - It also sets `curPC`<=`EXC_VECTOR` and applies the same kill/DROP rules as a redirect.
- `PCSEQ_EXC_EN` undefined:
  - Neither port exists, `EXC_VECTOR` is unused, and there is no exception logic.

## Test plan
- **Reset then zero-wait memory, `instr_ready`=1:** `imem_addr` sequence 0x0, 0x4, 0x8 on every second cycle; `instr_pc` matches each address.
- **Branch:** `redir_pc`=0x100, `PCSrc`=01, `immediate`=0xFFFF_FFFE while in VALID -> next `imem_addr`=0xFC and `instr_valid`=0 the next cycle.
- **Jump and jr:** jump with `redir_pc`=0x4000_0010, `addr`=0x0000040 -> 0x4000_0100. jr with `rs`=0x0000_1003 -> 0x0000_1000.
- **3-cycle memory with redirect in the 2nd wait cycle:** old address held until ack, returned data discarded, then a request to the target; no `instr_valid` for the killed word.
- **`stall`=1 for 5 cycles in VALID:** `instr`/`instr_pc` unchanged and `imem_req`=0 throughout; fetch resumes one cycle after `stall` falls.
- **With `PCSEQ_EXC_EN`:** `exc` while `instr_valid` with `instr_pc`=0x20 -> `epc`=0x20 and next `imem_addr`=0x180. `exc` together with `redir_valid` -> the exception wins.
